// File: rtl/div_radix2_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_radix2_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int          DIV_STEPS     = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with start/ready handshake.
// Optional DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 annul_i,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  div_state_t         r_state;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_part;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_q_neg;
  logic               r_r_neg;

  logic               w_abort;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_abs_dvd;
  logic [WIDTH-1:0]   w_abs_dvs;
  logic               w_dvs_zero;
  logic               w_early;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_part_nx;
  logic [WIDTH-1:0]   w_quot_nx;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_abort    = flush | annul_i;
  assign w_dvd_neg  = signed_div_i & opdata1_i[WIDTH-1];
  assign w_dvs_neg  = signed_div_i & opdata2_i[WIDTH-1];
  assign w_abs_dvd  = w_dvd_neg ? (ZERO_W - opdata1_i) : opdata1_i;
  assign w_abs_dvs  = w_dvs_neg ? (ZERO_W - opdata2_i) : opdata2_i;
  assign w_dvs_zero = (opdata2_i == ZERO_W);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = ~w_dvs_zero & (w_abs_dvd < w_abs_dvs);
`else
  assign w_early = 1'b0;
`endif

  // Partial remainder stays below the divisor, so a negative trial always shows in the top bit.
  assign w_trial   = {r_part, r_dvd[WIDTH-1]} - {1'b0, r_dvs};
  assign w_part_nx = w_trial[WIDTH] ? {r_part[WIDTH-2:0], r_dvd[WIDTH-1]} : w_trial[WIDTH-1:0];
  assign w_quot_nx = {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_q_fix   = r_q_neg ? (ZERO_W - w_quot_nx) : w_quot_nx;
  assign w_r_fix   = r_r_neg ? (ZERO_W - w_part_nx) : w_part_nx;

  // Control FSM, step datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= DIV_IDLE;
      r_ready  <= 1'b0;
      r_result <= {2*WIDTH{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_part   <= ZERO_W;
      r_dvd    <= ZERO_W;
      r_dvs    <= ZERO_W;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else if (w_abort) begin
      r_state <= DIV_IDLE;
      r_ready <= 1'b0;
      r_count <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_ready <= 1'b0;
          if (start_i) begin
            if (w_dvs_zero) begin
              r_result <= {opdata1_i, ZERO_QUOT};
              r_ready  <= 1'b1;
              r_state  <= DIV_DONE;
            end else if (w_early) begin
              r_result <= {opdata1_i, ZERO_W};
              r_ready  <= 1'b1;
              r_state  <= DIV_DONE;
            end else begin
              r_part  <= ZERO_W;
              r_dvd   <= w_abs_dvd;
              r_dvs   <= w_abs_dvs;
              r_q_neg <= w_dvd_neg ^ w_dvs_neg;
              r_r_neg <= w_dvd_neg;
              r_count <= {CNT_W{1'b0}};
              r_state <= DIV_BUSY;
            end
          end else begin
            r_state <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          r_part  <= w_part_nx;
          r_dvd   <= w_quot_nx;
          r_count <= r_count + CNT_ONE;
          if (r_count == CNT_LAST) begin
            r_result <= {w_r_fix, w_q_fix};
            r_ready  <= 1'b1;
            r_state  <= DIV_DONE;
          end else begin
            r_ready <= 1'b0;
            r_state <= DIV_BUSY;
          end
        end
        DIV_DONE: begin
          r_ready <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign result_o = r_result;

endmodule

// File: tb/tb_div_radix2.sv
// Directed self-checking bench for div_radix2: latency, results, flush/annul and reset.
module tb_div_radix2;
  import div_radix2_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        annul_i;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        ready_o;
  logic [63:0] result_o;

  int n_checks;
  int n_pass;

  div_radix2 #(.WIDTH(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .annul_i      (annul_i),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .ready_o      (ready_o),
    .result_o     (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request before an edge; returns #1 after the sampling edge N.
  task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input logic hold);
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_i = 1'b0;
  endtask

  // Called #1 after edge N: checks edges-to-ready, result and single-cycle pulse.
  task automatic wait_result(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {63'd0, ready_o}, 64'd0);
  endtask

  // Counts ready pulses over a window of edges.
  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b1) pulses = pulses + 1;
    end
  endtask

  initial begin
    int pulses;
    int early_lat;
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b0;
    flush        = 1'b0;
    annul_i      = 1'b0;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    start_op(1'b0, 32'd100, 32'd7, 1'b0);
    wait_result("u 100/7", DIV_STEPS, 64'h00000002_0000000E);

    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_result("s -7/2", DIV_STEPS, 64'hFFFFFFFF_FFFFFFFD);

    start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_result("s 7/-2", DIV_STEPS, 64'h00000001_FFFFFFFD);

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_result("s min/-1", DIV_STEPS, 64'h00000000_80000000);

    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_result("u min/max", DIV_STEPS, 64'h80000000_00000000);

    start_op(1'b1, 32'd5, 32'd0, 1'b0);
    wait_result("s 5/0", 0, {32'h0000_0005, DIV_ZERO_QUOT});

    start_op(1'b0, 32'd5, 32'd0, 1'b0);
    wait_result("u 5/0", 0, {32'h0000_0005, DIV_ZERO_QUOT});

`ifdef DIV_EARLY_OUT_EN
    early_lat = 0;
`else
    early_lat = DIV_STEPS;
`endif
    start_op(1'b0, 32'd3, 32'd10, 1'b0);
    wait_result("u 3/10", early_lat, 64'h00000003_00000000);

    // Flush at step 10 with start held; flush also covers one IDLE edge with start high.
    start_op(1'b0, 32'd100, 32'd7, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    count_pulses(2, pulses);
    check("flush no pulse", 64'(pulses), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_result("restart 100/7", DIV_STEPS, 64'h00000002_0000000E);

    // Annul mid-operation must suppress the result.
    start_op(1'b0, 32'd50, 32'd3, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    count_pulses(40, pulses);
    check("annul no pulse", 64'(pulses), 64'd0);
    check("annul result kept", result_o, 64'h00000002_0000000E);

    // Reset at step 20.
    start_op(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst ready", {63'd0, ready_o}, 64'd0);
    check("midrst result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    count_pulses(40, pulses);
    check("midrst no pulse", 64'(pulses), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
